pc_ras_unit: RTL

- Parametrised program-counter unit for the MIPS fetch stage. Successor to the single-jump-input counter.
- Adds a parametrised address width, step, reset and exception vectors, and prioritised redirect sources (exception, return, jump, branch).
- Adds a circular return-address stack (RAS) that serves call/return prediction, plus an exception PC (EPC) save register.
- Drives the instruction memory address; control comes from the decode/execute stages and the hazard unit.

---
 rtl/pc_ras_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with prioritised redirects, a circular
// return-address stack for call/return prediction, and an exception PC register.
module pc_ras_unit #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            STEP         = 1,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0]  EXC_VECTOR   = ADDR_WIDTH'(32'h80),
  parameter int unsigned            RAS_DEPTH    = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             exception,
  input  logic                             ret,
  input  logic                             jump,
  input  logic                             call,
  input  logic [ADDR_WIDTH-1:0]            jump_target,
  input  logic                             branch,
  input  logic [ADDR_WIDTH-1:0]            branch_target,
  output logic [ADDR_WIDTH-1:0]            instruction_address,
  output logic [ADDR_WIDTH-1:0]            epc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow,
  output logic                             redirected
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CountMax = CntW'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  redir_q, redir_d;
  logic                  push_en;

  assign pc_inc  = pc_q + ADDR_WIDTH'(STEP);
  // Top read combinationally so a pop and the PC load share one edge.
  assign ras_top = ras_q[ptr_q];

  always_comb begin
    pc_d    = pc_inc;
    epc_d   = epc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    redir_d = 1'b1;
    push_en = 1'b0;
    if (exception) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (ret) begin
      if (cnt_q != '0) begin
        pc_d  = ras_top;
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end else begin
        pc_d  = jump_target;
        unf_d = 1'b1;
      end
    end else if (jump) begin
      pc_d = jump_target;
      if (call) begin
        push_en = 1'b1;
        ptr_d   = ptr_q + PtrW'(1);
        // A full stack wraps onto its oldest entry; depth stays saturated.
        if (cnt_q == CountMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end else if (branch) begin
      pc_d = branch_target;
    end else if (stall) begin
      pc_d    = pc_q;
      redir_d = 1'b0;
    end else begin
      redir_d = 1'b0;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      redir_q <= redir_d;
    end
  end

  always_ff @(negedge clock) begin
    if (push_en && !reset) begin
      ras_q[ptr_d] <= pc_inc;
    end
  end

  assign instruction_address = pc_q;
  assign epc                 = epc_q;
  assign ras_count           = cnt_q;
  assign ras_overflow        = ovf_q;
  assign ras_underflow       = unf_q;
  assign redirected          = redir_q;

endmodule
